lamp_card_responder: RTL and testbench

Target-side model of one lamp card on the parallel lamp bus. It decodes board select, address, and the read/write/test/reset strobes driven by the command controller, and holds eight 8-bit registers. On reads it drives the shared data port. It is used as a loopback target on a second board and as the bus model in the controller's testbench.

---
 rtl/lamp_card_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_lamp_card_responder.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_card_responder.sv
// lamp_card_responder
//
// Target-side model of one lamp card on the parallel lamp bus. It decodes
// board select, address and the active-low read/write/test/reset strobes,
// holds seven 8-bit registers plus an accepted-write counter, and drives the
// shared data port during reads.
//
// Optional feature macro: LAMP_RESPONDER_ADC_SIM_EN
//   defined   - register 6 is read-only and counts completed non-test reads
//               (simulated ADC sample)
//   undefined - register 6 is a plain read/write register
//
// Parameters:
//   BOARD_ID     board select value this card answers to
//   SYNC_STAGES  synchronizer depth on all bus inputs (>= 2)
//
// Ports:
//   clock           system clock
//   reset_n         asynchronous active-low reset
//   data_in         data port pins as seen by this card
//   data_out        data driven during reads
//   data_oe         1 = drive the data port (tristated at top level otherwise)
//   AddessPortPin   register address
//   BOARD_X         board select
//   RdP             read strobe, active-low
//   WrP             write strobe, active-low
//   TestAddressP    test qualifier, active-low
//   LampResetPin    lamp reset, active-low
//   lamp_state      {reg5..reg0}
//   protocol_error  sticky, set when RdP and WrP are low together

module lamp_card_responder #(
    parameter logic [3:0] BOARD_ID    = 4'h0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [2:0]  AddessPortPin,
    input  logic [3:0]  BOARD_X,
    input  logic        RdP,
    input  logic        WrP,
    input  logic        TestAddressP,
    input  logic        LampResetPin,
    output logic [47:0] lamp_state,
    output logic        protocol_error
);

    localparam int BUS_W = 19;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    // Address 7 is the counter; under the ADC option address 6 is read-only.
    function automatic logic is_writable(input logic [2:0] a);
`ifdef LAMP_RESPONDER_ADC_SIM_EN
        return (a != 3'd7) && (a != 3'd6);
`else
        return (a != 3'd7);
`endif
    endfunction

    logic [BUS_W-1:0] bus_raw;
    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic [BUS_W-1:0] bus_s;

    logic [7:0] data_s;
    logic [2:0] addr_s;
    logic [3:0] bx_s;
    logic       rd_s, wr_s, test_s, lrst_s;

    logic       rd_q_p0, wr_q_p0;

    logic       rd_fall_p1, rd_rise_p1, wr_fall_p1, wr_rise_p1;
    logic       rd_lvl_p1, wr_lvl_p1, lrst_lvl_p1, test_p1;
    logic [2:0] addr_p1;
    logic [7:0] data_p1;
    logic [3:0] bx_p1;

    logic [1:0] state;
    logic [7:0] lamp_reg [8];
    logic [7:0] wr_count;
    logic       board_match;
`ifdef LAMP_RESPONDER_ADC_SIM_EN
    logic       read_is_test;
`endif

    assign bus_raw = {LampResetPin, TestAddressP, WrP, RdP, BOARD_X, AddessPortPin, data_in};

    // Synchronizer chain: every bus input, reset to idle-high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= bus_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus_s  = sync_q[SYNC_STAGES-1];
    assign data_s = bus_s[7:0];
    assign addr_s = bus_s[10:8];
    assign bx_s   = bus_s[14:11];
    assign rd_s   = bus_s[15];
    assign wr_s   = bus_s[16];
    assign test_s = bus_s[17];
    assign lrst_s = bus_s[18];

    // Stage p0: previous strobe levels for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q_p0 <= 1'b1;
            wr_q_p0 <= 1'b1;
        end else begin
            rd_q_p0 <= rd_s;
            wr_q_p0 <= wr_s;
        end
    end

    // Stage p1: registered edge pulses, levels and qualifiers, all aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_fall_p1  <= 1'b0;
            rd_rise_p1  <= 1'b0;
            wr_fall_p1  <= 1'b0;
            wr_rise_p1  <= 1'b0;
            rd_lvl_p1   <= 1'b1;
            wr_lvl_p1   <= 1'b1;
            lrst_lvl_p1 <= 1'b1;
            test_p1     <= 1'b1;
            addr_p1     <= '0;
            data_p1     <= '0;
            bx_p1       <= '0;
        end else begin
            rd_fall_p1  <= rd_q_p0 & ~rd_s;
            rd_rise_p1  <= ~rd_q_p0 & rd_s;
            wr_fall_p1  <= wr_q_p0 & ~wr_s;
            wr_rise_p1  <= ~wr_q_p0 & wr_s;
            rd_lvl_p1   <= rd_s;
            wr_lvl_p1   <= wr_s;
            lrst_lvl_p1 <= lrst_s;
            test_p1     <= test_s;
            addr_p1     <= addr_s;
            data_p1     <= data_s;
            bx_p1       <= bx_s;
        end
    end

    assign board_match = (bx_p1 == BOARD_ID);

    // Stage p2: bus FSM, register file, counter and data port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            data_out       <= 8'h00;
            data_oe        <= 1'b0;
            protocol_error <= 1'b0;
            wr_count       <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                lamp_reg[i] <= 8'h00;
            end
`ifdef LAMP_RESPONDER_ADC_SIM_EN
            read_is_test   <= 1'b0;
`endif
        end else if (!lrst_lvl_p1) begin
            // Lamp reset wins over everything; the counter survives it.
            for (int i = 0; i < 7; i++) begin
                lamp_reg[i] <= 8'h00;
            end
            data_oe <= 1'b0;
            state   <= ST_IDLE;
        end else if (!rd_lvl_p1 && !wr_lvl_p1) begin
            // Bus collision: abort, commit nothing, hold in ERR until both release.
            protocol_error <= 1'b1;
            data_oe        <= 1'b0;
            state          <= ST_ERR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_fall_p1 && board_match) begin
                        state <= ST_WRITE;
                        if (is_writable(addr_p1)) begin
                            lamp_reg[addr_p1] <= data_p1;
                            wr_count          <= wr_count + 8'd1;
                        end
                    end else if (rd_fall_p1 && board_match) begin
                        state   <= ST_READ;
                        data_oe <= 1'b1;
                        if (!test_p1) begin
                            data_out <= {BOARD_ID, 1'b0, addr_p1};
                        end else if (addr_p1 == 3'd7) begin
                            data_out <= wr_count;
                        end else begin
                            data_out <= lamp_reg[addr_p1];
                        end
`ifdef LAMP_RESPONDER_ADC_SIM_EN
                        read_is_test <= ~test_p1;
`endif
                    end
                end
                ST_WRITE: begin
                    if (wr_rise_p1) begin
                        state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (rd_rise_p1) begin
                        state   <= ST_IDLE;
                        data_oe <= 1'b0;
`ifdef LAMP_RESPONDER_ADC_SIM_EN
                        // Next simulated sample only once this read has been returned.
                        if (!read_is_test) begin
                            lamp_reg[6] <= lamp_reg[6] + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    if (rd_lvl_p1 && wr_lvl_p1) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Lamp outputs trail the register file by one clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lamp_state <= '0;
        end else begin
            lamp_state <= {lamp_reg[5], lamp_reg[4], lamp_reg[3],
                           lamp_reg[2], lamp_reg[1], lamp_reg[0]};
        end
    end

endmodule

// File: tb/tb_lamp_card_responder.sv
`timescale 1ns/1ps

module tb_lamp_card_responder;

    localparam int         S   = 2;
    localparam logic [3:0] BID = 4'h2;
    localparam int         LAT = S + 2;

    logic        clock;
    logic        reset_n;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [2:0]  AddessPortPin;
    logic [3:0]  BOARD_X;
    logic        RdP;
    logic        WrP;
    logic        TestAddressP;
    logic        LampResetPin;
    logic [47:0] lamp_state;
    logic        protocol_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] mreg [8];
    logic [7:0] mcnt;

    lamp_card_responder #(.BOARD_ID(BID), .SYNC_STAGES(S)) dut (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), .AddessPortPin(AddessPortPin), .BOARD_X(BOARD_X),
        .RdP(RdP), .WrP(WrP), .TestAddressP(TestAddressP), .LampResetPin(LampResetPin),
        .lamp_state(lamp_state), .protocol_error(protocol_error)
    );

    initial clock = 1'b0;
    always #18 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic void model_write(input logic [2:0] a, input logic [7:0] d, input logic [3:0] bx);
        bit ok;
        ok = (bx == BID) && (a != 3'd7);
`ifdef LAMP_RESPONDER_ADC_SIM_EN
        if (a == 3'd6) ok = 0;
`endif
        if (ok) begin
            mreg[a] = d;
            mcnt    = mcnt + 8'd1;
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [2:0] a, input bit is_test);
        logic [7:0] v;
        if (is_test)        v = {BID, 1'b0, a};
        else if (a == 3'd7) v = mcnt;
        else                v = mreg[a];
`ifdef LAMP_RESPONDER_ADC_SIM_EN
        if (!is_test) mreg[6] = mreg[6] + 8'd1;
`endif
        return v;
    endfunction

    function automatic logic [47:0] model_lamps();
        logic [47:0] l;
        for (int k = 0; k < 6; k++) l[k*8 +: 8] = mreg[k];
        return l;
    endfunction

    function automatic void model_lamp_reset();
        for (int k = 0; k < 7; k++) mreg[k] = 8'h00;
    endfunction

    // ---------------- bus drivers ----------------
    task automatic do_write(input logic [2:0] a, input logic [7:0] d, input logic [3:0] bx);
        @(posedge clock); #1;
        AddessPortPin = a; data_in = d; BOARD_X = bx;
        repeat (2) @(posedge clock);
        #1 WrP = 1'b0;
        repeat (8) @(posedge clock);
        #1 WrP = 1'b1;
        repeat (7) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_read(input logic [2:0] a, input logic [3:0] bx, input bit is_test,
                           output logic [7:0] val, output int hi_at, output int lo_at,
                           output logic pre_oe);
        val = 8'h00; hi_at = 0; lo_at = 0;
        @(posedge clock); #1;
        AddessPortPin = a; BOARD_X = bx; TestAddressP = !is_test;
        repeat (2) @(posedge clock);
        @(negedge clock);
        pre_oe = data_oe;
        @(posedge clock); #1 RdP = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clock); @(negedge clock);
            if (data_oe === 1'b1) begin
                if (hi_at == 0) hi_at = i;
                val = data_out;
            end
        end
        @(posedge clock); #1 RdP = 1'b1; TestAddressP = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(posedge clock); @(negedge clock);
            if (data_oe !== 1'b1 && lo_at == 0 && hi_at != 0) lo_at = j;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        data_in = 8'h00; AddessPortPin = 3'd0; BOARD_X = BID;
        RdP = 1'b1; WrP = 1'b1; TestAddressP = 1'b1; LampResetPin = 1'b1;
        for (int k = 0; k < 8; k++) mreg[k] = 8'h00;
        mcnt = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (data_out !== 8'h00 || data_oe !== 1'b0 || lamp_state !== 48'h0 || protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data_out=%h oe=%b lamps=%h perr=%b, required 00 0 0 0",
                     data_out, data_oe, lamp_state, protocol_error);
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++;
        if (data_oe !== 1'b0 || protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: oe=%b perr=%b, required 0 0", data_oe, protocol_error);
        end
    endtask

    task automatic test_write_readback();
        logic [7:0] v; int hi, lo; logic pre;
        do_write(3'd3, 8'hA5, BID);
        model_write(3'd3, 8'hA5, BID);
        checks++;
        if (lamp_state[31:24] !== 8'hA5) begin
            errors++;
            $display("FAIL wr_lamp3: got %h, required a5", lamp_state[31:24]);
        end
        do_read(3'd3, BID, 0, v, hi, lo, pre);
        checks++;
        if (v !== model_read(3'd3, 0) || pre !== 1'b0) begin
            errors++;
            $display("FAIL rd_addr3: data=%h pre_oe=%b, required a5 0", v, pre);
        end
        checks++;
        if (hi != LAT || lo != LAT) begin
            errors++;
            $display("FAIL rd_window: oe rose at %0d fell at %0d, required %0d %0d", hi, lo, LAT, LAT);
        end
        do_read(3'd7, BID, 0, v, hi, lo, pre);
        checks++;
        if (v !== model_read(3'd7, 0) || v !== 8'd1) begin
            errors++;
            $display("FAIL rd_counter: got %h, required 01", v);
        end
    endtask

    task automatic test_mismatch();
        logic [7:0] v, ev; int hi, lo; logic pre;
        do_write(3'd0, 8'h3C, BID + 4'd1);
        model_write(3'd0, 8'h3C, BID + 4'd1);
        do_read(3'd0, BID + 4'd1, 0, v, hi, lo, pre);
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL mismatch_oe: oe asserted at clock %0d, required never", hi);
        end
        do_read(3'd0, BID, 0, v, hi, lo, pre);
        ev = model_read(3'd0, 0);
        checks++;
        if (v !== ev || v !== 8'h00) begin
            errors++;
            $display("FAIL mismatch_reg0: got %h, required %h", v, ev);
        end
        do_read(3'd7, BID, 0, v, hi, lo, pre);
        ev = model_read(3'd7, 0);
        checks++;
        if (v !== ev) begin
            errors++;
            $display("FAIL mismatch_count: got %h, required %h", v, ev);
        end
    endtask

    task automatic test_test_read();
        logic [7:0] v; int hi, lo; logic pre;
        do_read(3'd5, BID, 1, v, hi, lo, pre);
        void'(model_read(3'd5, 1));
        checks++;
        if (v !== 8'h25 || hi != LAT) begin
            errors++;
            $display("FAIL test_read: data=%h at %0d, required 25 at %0d", v, hi, LAT);
        end
    endtask

    task automatic test_random();
        logic [7:0] v, ev, d; logic [2:0] a; logic [3:0] bx; int hi, lo, op; logic pre; bit tst;
        for (int n = 0; n < 40; n++) begin
            a  = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            bx = ($urandom_range(0, 3) == 0) ? 4'h7 : BID;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_write(a, d, bx);
                model_write(a, d, bx);
                checks++;
                if (lamp_state !== model_lamps()) begin
                    errors++;
                    $display("FAIL rand_write[%0d]: lamps=%h, required %h", n, lamp_state, model_lamps());
                end
            end else begin
                tst = (op == 2);
                do_read(a, bx, tst, v, hi, lo, pre);
                checks++;
                if (bx == BID) begin
                    ev = model_read(a, tst);
                    if (v !== ev || hi != LAT || lo != LAT) begin
                        errors++;
                        $display("FAIL rand_read[%0d]: addr=%0d data=%h hi=%0d lo=%0d, required %h %0d %0d",
                                 n, a, v, hi, lo, ev, LAT, LAT);
                    end
                end else if (hi != 0) begin
                    errors++;
                    $display("FAIL rand_unmatched[%0d]: oe at %0d, required never", n, hi);
                end
            end
        end
        checks++;
        if (protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL rand_perr: got %b, required 0", protocol_error);
        end
    endtask

    task automatic test_counter_wrap();
        logic [7:0] v, ev; int hi, lo, n; logic pre;
        n = (mcnt == 8'h00) ? 256 : 256 - int'(mcnt);
        for (int k = 0; k < n; k++) begin
            do_write(3'd0, 8'(k), BID);
            model_write(3'd0, 8'(k), BID);
        end
        do_write(3'd7, 8'h99, BID);
        model_write(3'd7, 8'h99, BID);
        do_read(3'd7, BID, 0, v, hi, lo, pre);
        ev = model_read(3'd7, 0);
        checks++;
        if (v !== ev || v !== 8'h00) begin
            errors++;
            $display("FAIL counter_wrap: got %h, required 00", v);
        end
    endtask

    task automatic test_reg6();
        logic [7:0] v, ev; int hi, lo; logic pre;
`ifdef LAMP_RESPONDER_ADC_SIM_EN
        do_write(3'd6, 8'h5A, BID);
        model_write(3'd6, 8'h5A, BID);
        for (int k = 0; k < 3; k++) begin
            do_read(3'd6, BID, 0, v, hi, lo, pre);
            ev = model_read(3'd6, 0);
            checks++;
            if (v !== ev) begin
                errors++;
                $display("FAIL adc_read[%0d]: got %h, required %h", k, v, ev);
            end
        end
`else
        do_write(3'd6, 8'h5A, BID);
        model_write(3'd6, 8'h5A, BID);
        do_read(3'd6, BID, 0, v, hi, lo, pre);
        ev = model_read(3'd6, 0);
        checks++;
        if (v !== 8'h5A || v !== ev) begin
            errors++;
            $display("FAIL reg6_rw: got %h, required 5a", v);
        end
`endif
        do_read(3'd7, BID, 0, v, hi, lo, pre);
        ev = model_read(3'd7, 0);
        checks++;
        if (v !== ev) begin
            errors++;
            $display("FAIL reg6_count: got %h, required %h", v, ev);
        end
    endtask

    task automatic test_collision();
        logic [7:0] v, ev; int hi, lo, fell; logic pre;
        do_write(3'd2, 8'h11, BID);
        model_write(3'd2, 8'h11, BID);
        @(posedge clock); #1;
        AddessPortPin = 3'd2; BOARD_X = BID; TestAddressP = 1'b1;
        repeat (2) @(posedge clock);
        #1 RdP = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        checks++;
        if (data_oe !== 1'b1 || data_out !== 8'h11) begin
            errors++;
            $display("FAIL coll_read_active: oe=%b data=%h, required 1 11", data_oe, data_out);
        end
        @(posedge clock); #1;
        data_in = 8'hEE; WrP = 1'b0;
        fell = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clock); @(negedge clock);
            if (data_oe !== 1'b1 && fell == 0) fell = i;
        end
        checks++;
        if (fell == 0 || fell > LAT || protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL coll_abort: oe fell at %0d perr=%b, required <=%0d 1", fell, protocol_error, LAT);
        end
        @(posedge clock); #1 RdP = 1'b1; WrP = 1'b1;
        repeat (8) @(posedge clock);
        @(negedge clock);
        checks++;
        if (protocol_error !== 1'b1 || data_oe !== 1'b0) begin
            errors++;
            $display("FAIL coll_sticky: perr=%b oe=%b, required 1 0", protocol_error, data_oe);
        end
        do_read(3'd2, BID, 0, v, hi, lo, pre);
        ev = model_read(3'd2, 0);
        checks++;
        if (v !== ev || v !== 8'h11) begin
            errors++;
            $display("FAIL coll_nocommit: got %h, required %h", v, ev);
        end
        do_read(3'd7, BID, 0, v, hi, lo, pre);
        ev = model_read(3'd7, 0);
        checks++;
        if (v !== ev) begin
            errors++;
            $display("FAIL coll_count: got %h, required %h", v, ev);
        end
    endtask

    task automatic test_lamp_reset();
        logic [7:0] v, ev; int hi, lo; logic pre;
        do_write(3'd1, 8'h77, BID);
        model_write(3'd1, 8'h77, BID);
        do_write(3'd4, 8'hC3, BID);
        model_write(3'd4, 8'hC3, BID);
        @(posedge clock); #1;
        AddessPortPin = 3'd1; BOARD_X = BID; TestAddressP = 1'b1;
        repeat (2) @(posedge clock);
        #1 RdP = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        checks++;
        if (data_oe !== 1'b1 || data_out !== 8'h77) begin
            errors++;
            $display("FAIL lrst_read_active: oe=%b data=%h, required 1 77", data_oe, data_out);
        end
        @(posedge clock); #1 LampResetPin = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        checks++;
        if (data_oe !== 1'b0) begin
            errors++;
            $display("FAIL lrst_oe: got %b, required 0", data_oe);
        end
        model_lamp_reset();
        @(posedge clock); #1 LampResetPin = 1'b1;
        repeat (6) @(posedge clock);
        #1 RdP = 1'b1;
        repeat (6) @(posedge clock);
        @(negedge clock);
        checks++;
        if (lamp_state !== model_lamps() || data_oe !== 1'b0) begin
            errors++;
            $display("FAIL lrst_lamps: lamps=%h oe=%b, required %h 0", lamp_state, data_oe, model_lamps());
        end
        for (int k = 0; k < 8; k++) begin
            do_read(3'(k), BID, 0, v, hi, lo, pre);
            ev = model_read(3'(k), 0);
            checks++;
            if (v !== ev) begin
                errors++;
                $display("FAIL lrst_reg%0d: got %h, required %h", k, v, ev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_mismatch();
        test_test_read();
        test_random();
        test_counter_wrap();
        test_reg6();
        test_collision();
        test_lamp_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
